frog_move_encoder: RTL and testbench

Converts the four raw board push-buttons into the clean, mutually exclusive, single-cycle move strobes `L`, `U`, `D`, `R` consumed by every frog cell of the LED array, including the start-row cell. Each button is synchronized and debounced. A small arbiter then emits at most one strobe per physical press, and only when exactly one direction is active. The block sits between the board KEY pins and the frog cell array, and drives the same strobes to all cells.

---
 rtl/frog_move_encoder.sv | 103 ++++++++++
 tb/tb_frog_move_encoder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frog_move_encoder.sv
// Move encoder for the four board buttons. Each button is synchronized and debounced.
// An arbiter then emits at most one single-cycle L/U/D/R strobe per press.
module frog_move_encoder #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic rawL,
    input  logic rawU,
    input  logic rawD,
    input  logic rawR,
    output logic L,
    output logic U,
    output logic D,
    output logic R,
    output logic held
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Bit order everywhere: [0]=L, [1]=U, [2]=D, [3]=R
    logic [3:0]    pol;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    db;
    logic [3:0]    db_prev;
    logic [3:0]    rise;
    logic          single_press;
    logic [CW-1:0] cnt [4];
    state_t        state;

    assign pol          = {rawR, rawD, rawU, rawL} ^ {4{ACTIVE_LOW}};
    assign rise         = db & ~db_prev;
    assign single_press = $onehot(rise) && (db == rise);

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1   <= pol;
            sync2   <= sync1;
            db_prev <= db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            {R, D, U, L} <= 4'b0000;
            held         <= 1'b0;
        end else begin
            // Strobes default low each cycle so a move is exactly one cycle wide.
            {R, D, U, L} <= 4'b0000;
            case (state)
                IDLE: begin
                    if (enable && single_press) begin
                        {R, D, U, L} <= rise;
                        state        <= HELD;
                        held         <= 1'b1;
                    end else if (|db) begin
                        state <= HELD;
                        held  <= 1'b1;
                    end
                end
                HELD: begin
                    if (db == 4'b0000) begin
                        state <= IDLE;
                        held  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frog_move_encoder.sv
// Bench for frog_move_encoder. Directed scenarios carry literal expectations.
// A randomized phase is compared every cycle against a window-based behavioural model.
module tb_frog_move_encoder;

    localparam int DC = 4;
    localparam bit AL = 1'b0;

    logic clk;
    logic reset;
    logic enable;
    logic rawL, rawU, rawD, rawR;
    logic L, U, D, R, held;

    int tests = 0;
    int fails = 0;
    bit cmp_on = 0;

    frog_move_encoder #(
        .DEBOUNCE_CYCLES(DC),
        .ACTIVE_LOW     (AL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .rawL  (rawL),
        .rawU  (rawU),
        .rawD  (rawD),
        .rawR  (rawR),
        .L     (L),
        .U     (U),
        .D     (D),
        .R     (R),
        .held  (held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: s is the polarity-corrected input delayed by two edges.
    // A debounced level flips once the last DC samples of s all disagree with it.
    logic [3:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_dbp = '0, m_strobe = '0;
    bit         m_held = 0;
    logic [3:0] m_hist[$];

    initial begin
        logic [3:0] nxt, rise, pnow;
        bit differ;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0; m_strobe = '0; m_held = 0;
                m_hist.delete();
            end else begin
                pnow = {rawR, rawD, rawU, rawL} ^ {4{AL}};
                m_hist.push_back(m_s2);
                if (m_hist.size() > DC) void'(m_hist.pop_front());
                nxt = m_db;
                if (m_hist.size() == DC) begin
                    for (int b = 0; b < 4; b++) begin
                        differ = 1;
                        foreach (m_hist[k]) if (m_hist[k][b] == m_db[b]) differ = 0;
                        if (differ) nxt[b] = ~m_db[b];
                    end
                end
                rise     = m_db & ~m_dbp;
                m_strobe = '0;
                if (!m_held) begin
                    if (enable && $countones(rise) == 1 && m_db == rise) begin
                        m_strobe = rise;
                        m_held   = 1;
                    end else if (m_db != 0) begin
                        m_held = 1;
                    end
                end else if (m_db == 0) begin
                    m_held = 0;
                end
                m_dbp = m_db;
                m_db  = nxt;
                m_s2  = m_s1;
                m_s1  = pnow;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                check("outputs vs model", 32'({R, D, U, L, held}), 32'({m_strobe, m_held}));
                check("strobe exclusivity", 32'($countones({L, U, D, R}) <= 1), 32'd1);
            end
        end
    end

    // Per-scenario observation: strobe counts, first strobe cycle, held extent.
    int cnt_s[4];
    int first_k[4];
    int held_cnt, held_first, held_last;

    task automatic clear_obs();
        for (int b = 0; b < 4; b++) begin
            cnt_s[b]   = 0;
            first_k[b] = 0;
        end
        held_cnt   = 0;
        held_first = 0;
        held_last  = 0;
    endtask

    task automatic run(input int n);
        logic [3:0] st;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            st = {R, D, U, L};
            for (int b = 0; b < 4; b++) begin
                if (st[b]) begin
                    cnt_s[b]++;
                    if (first_k[b] == 0) first_k[b] = k;
                end
            end
            if (held) begin
                held_cnt++;
                held_last = k;
                if (held_first == 0) held_first = k;
            end
        end
    endtask

    task automatic set_raw(input logic [3:0] v);
        {rawR, rawD, rawU, rawL} = v ^ {4{AL}};
    endtask

    initial begin
        logic [3:0] pat;
        int r;
        int rk;
        int rc;
        reset  = 1'b1;
        enable = 1'b1;
        set_raw(4'b0000);
        #1 cmp_on = 1;
        repeat (2) @(negedge clk);
        check("reset outputs", 32'({L, U, D, R, held}), 32'd0);
        reset = 1'b0;
        run(3);

        // Single L press held for 20 cycles.
        clear_obs();
        set_raw(4'b0001);
        run(20);
        check("L count", cnt_s[0], 1);
        check("L strobe cycle", first_k[0], 7);
        check("U/D/R quiet on L", cnt_s[1] + cnt_s[2] + cnt_s[3], 0);
        check("held first cycle", held_first, 7);
        clear_obs();
        set_raw(4'b0000);
        run(10);
        check("held last after release", held_last, 6);

        // Bouncing U shorter than the debounce window.
        clear_obs();
        set_raw(4'b0010); run(2);
        set_raw(4'b0000); run(2);
        set_raw(4'b0010); run(2);
        set_raw(4'b0000); run(12);
        check("bounce strobes", cnt_s[0] + cnt_s[1] + cnt_s[2] + cnt_s[3], 0);
        check("bounce held", held_cnt, 0);

        // U and R together, then D alone.
        clear_obs();
        set_raw(4'b1010);
        run(15);
        check("U+R strobes", cnt_s[0] + cnt_s[1] + cnt_s[2] + cnt_s[3], 0);
        check("U+R held", 32'(held), 32'd1);
        set_raw(4'b0000);
        run(10);
        check("U+R released", 32'(held), 32'd0);
        clear_obs();
        set_raw(4'b0100);
        run(12);
        check("D after U+R", cnt_s[2], 1);
        check("D only", cnt_s[0] + cnt_s[1] + cnt_s[3], 0);
        set_raw(4'b0000);
        run(10);

        // L, then R added while held.
        clear_obs();
        set_raw(4'b0001); run(10);
        set_raw(4'b1001); run(10);
        set_raw(4'b0000); run(10);
        check("L then R: L count", cnt_s[0], 1);
        check("L then R: R count", cnt_s[3], 0);
        clear_obs();
        set_raw(4'b1000); run(12);
        check("R alone", cnt_s[3], 1);
        set_raw(4'b0000); run(10);

        // D pressed with enable low, enable raised while held.
        clear_obs();
        enable = 1'b0;
        set_raw(4'b0100); run(10);
        enable = 1'b1;
        run(10);
        check("disabled D", cnt_s[2], 0);
        set_raw(4'b0000); run(10);
        clear_obs();
        set_raw(4'b0100); run(12);
        check("re-pressed D", cnt_s[2], 1);
        set_raw(4'b0000); run(10);

        // Asynchronous reset while R is held.
        clear_obs();
        set_raw(4'b1000);
        run(12);
        check("R before reset", cnt_s[3], 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async reset R", 32'(R), 32'd0);
        check("async reset held", 32'(held), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rc = 0;
        rk = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (R) begin
                rc++;
                if (rk == 0) rk = k;
            end
        end
        check("post-reset R count", rc, 1);
        check("post-reset R edge", rk, 7);
        @(negedge clk);
        set_raw(4'b0000);
        run(10);

        // Randomized phase, checked against the model every cycle.
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            if (r < 5)      pat = 4'(1 << $urandom_range(0, 3));
            else if (r < 7) pat = 4'($urandom_range(1, 15));
            else            pat = 4'b0000;
            set_raw(pat);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) == 0) begin
                #3 reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
            run($urandom_range(1, 12));
        end
        set_raw(4'b0000);
        enable = 1'b1;
        run(15);

        cmp_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
